led_breathe_driver: RTL



---
 rtl/led_breathe_driver.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/led_breathe_driver.sv
// LED breathing driver: an 8-bit PWM whose duty follows a triangular brightness
// envelope, gated by a spatial pattern mask (all, scanner, binary count, off).
module led_breathe_driver #(
    parameter int unsigned STEP = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    output logic [7:0] leds
);

    localparam int unsigned StepW = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [StepW-1:0] StepLast = StepW'(STEP - 1);

    typedef enum logic {
        StRise,
        StFall
    } env_state_e;

    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [StepW-1:0] step_cnt_q, step_cnt_d;
    env_state_e       state_q, state_d;
    logic [7:0]       level_q, level_d;
    logic [2:0]       pos_q, pos_d;
    logic             dir_down_q, dir_down_d;
    logic [7:0]       bcnt_q, bcnt_d;
    logic [7:0]       leds_q, leds_d;

    logic       frame_stb;
    logic       step_stb;
    logic       advance;
    logic [7:0] mask;

    // PWM and step counters; both hold while en is low
    always_comb begin
        pwm_cnt_d  = pwm_cnt_q;
        step_cnt_d = step_cnt_q;
        frame_stb  = en && (pwm_cnt_q == 8'hFF);
        step_stb   = frame_stb && (step_cnt_q == StepLast);
        if (en) begin
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end
        if (step_stb) begin
            step_cnt_d = '0;
        end else if (frame_stb) begin
            step_cnt_d = step_cnt_q + 1'b1;
        end
    end

    // Envelope FSM: triangle 0..255..0, advancing the pattern at the bottom turnaround
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        advance = 1'b0;
        if (step_stb) begin
            unique case (state_q)
                StRise: begin
                    if (level_q != 8'hFF) begin
                        level_d = level_q + 8'd1;
                    end else begin
                        state_d = StFall;
                        level_d = 8'd254;
                    end
                end
                StFall: begin
                    if (level_q != 8'h00) begin
                        level_d = level_q - 8'd1;
                    end else begin
                        state_d = StRise;
                        level_d = 8'd1;
                        advance = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pattern state: bouncing scanner and binary counter, both stepped by advance
    always_comb begin
        pos_d      = pos_q;
        dir_down_d = dir_down_q;
        bcnt_d     = bcnt_q;
        if (advance) begin
            bcnt_d = bcnt_q + 8'd1;
            if (!dir_down_q) begin
                if (pos_q == 3'd7) begin
                    pos_d      = 3'd6;
                    dir_down_d = 1'b1;
                end else begin
                    pos_d = pos_q + 3'd1;
                end
            end else begin
                if (pos_q == 3'd0) begin
                    pos_d      = 3'd1;
                    dir_down_d = 1'b0;
                end else begin
                    pos_d = pos_q - 3'd1;
                end
            end
        end
    end

    // Active mask selection and PWM gating; disabled cycles force the LEDs dark
    always_comb begin
        mask = 8'h00;
        unique case (mode)
            2'd0: mask = 8'hFF;
            2'd1: mask = 8'h01 << pos_q;
            2'd2: mask = bcnt_q;
            2'd3: mask = 8'h00;
            default: ;
        endcase
        leds_d = en ? (mask & {8{pwm_cnt_q < level_q}}) : 8'h00;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q  <= 8'h00;
            step_cnt_q <= '0;
            state_q    <= StRise;
            level_q    <= 8'h00;
            pos_q      <= 3'd0;
            dir_down_q <= 1'b0;
            bcnt_q     <= 8'h00;
            leds_q     <= 8'h00;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            state_q    <= state_d;
            level_q    <= level_d;
            pos_q      <= pos_d;
            dir_down_q <= dir_down_d;
            bcnt_q     <= bcnt_d;
            leds_q     <= leds_d;
        end
    end

    assign leds = leds_q;

endmodule
